batch_sequencer: RTL



---
 rtl/batch_sequencer_pkg.sv | 19 +
 rtl/batch_watchdog.sv | 38 +++
 rtl/batch_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/batch_sequencer_pkg.sv
// Shared types for the batch sequencer: FSM state encoding and watchdog sizing.
package batch_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        ERROR
    } batch_seq_state_e;

    localparam int unsigned WDOG_TIMEOUT_DEF = 1048576;
    localparam int unsigned WDOG_W_DEF       = $clog2(WDOG_TIMEOUT_DEF);

    function automatic int unsigned wdog_width(input int unsigned cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/batch_watchdog.sv
// Cycle counter for the WAIT state: clears while disabled, expires on its last count.
module batch_watchdog
    import batch_sequencer_pkg::*;
#(
    parameter int unsigned P_LIMIT = WDOG_TIMEOUT_DEF,
    parameter int unsigned P_W     = WDOG_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [P_W-1:0] LAST = P_W'(P_LIMIT - 1);

    logic [P_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/batch_sequencer.sv
// Runs a batch of start/done iterations across all engines.
// Define BATCH_SEQUENCER_WATCHDOG_EN to add the hung-engine watchdog and ERROR state.
module batch_sequencer
    import batch_sequencer_pkg::*;
#(
    parameter int unsigned P_NUM_ENGINES    = 4,
    parameter int unsigned P_ITER_W         = 16,
    parameter int unsigned P_TIMEOUT_CYCLES = WDOG_TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [P_ITER_W-1:0]      cmd_iters_i,
    input  logic                     abort_i,
    output logic [P_NUM_ENGINES-1:0] start_o,
    input  logic                     done_all_i,
    output logic [P_ITER_W-1:0]      iter_cnt_o,
    output logic                     busy_o,
    output logic                     batch_done_o,
    output logic                     aborted_o,
    output logic                     error_o
);

    batch_seq_state_e    state_q, state_d;
    logic [P_ITER_W-1:0] target_q, target_d;
    logic [P_ITER_W-1:0] iter_q, iter_d;
    logic [P_ITER_W-1:0] iter_inc;
    logic                start_q, start_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;
    logic                bdone_q, bdone_d;
    logic                aborted_q, aborted_d;
    logic                accept;
    logic                timeout;

    assign accept   = cmd_valid_i && ready_q;
    assign iter_inc = iter_q + 1'b1;

`ifdef BATCH_SEQUENCER_WATCHDOG_EN
    localparam int unsigned WDOG_W = wdog_width(P_TIMEOUT_CYCLES);

    logic error_q, error_d;

    batch_watchdog #(
        .P_LIMIT (P_TIMEOUT_CYCLES),
        .P_W     (WDOG_W)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q != WAIT),
        .en_i     (state_q == WAIT),
        .expire_o (timeout)
    );

    always_comb begin
        error_d = error_q;
        if (accept) begin
            error_d = 1'b0;
        end
        if (state_d == ERROR) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error_o = error_q;
`else
    assign timeout = 1'b0;
    assign error_o = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        iter_d   = iter_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    target_d = cmd_iters_i;
                    iter_d   = '0;
                    state_d  = (cmd_iters_i == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (done_all_i) begin
                    iter_d  = iter_inc;
                    state_d = (iter_inc == target_q) ? DONE : ISSUE;
                end else if (timeout) begin
                    state_d = ERROR;
                end
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort beats a coincident done or timeout and freezes the count.
        if (abort_i && state_q != IDLE) begin
            state_d = IDLE;
            iter_d  = iter_q;
        end
    end

    always_comb begin
        start_d   = (state_d == ISSUE);
        busy_d    = (state_d != IDLE);
        ready_d   = (state_d == IDLE);
        bdone_d   = (state_d == DONE);
        aborted_d = abort_i && (state_q != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            target_q  <= '0;
            iter_q    <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            bdone_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            iter_q    <= iter_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            bdone_q   <= bdone_d;
            aborted_q <= aborted_d;
        end
    end

    assign start_o      = {P_NUM_ENGINES{start_q}};
    assign cmd_ready_o  = ready_q;
    assign iter_cnt_o   = iter_q;
    assign busy_o       = busy_q;
    assign batch_done_o = bdone_q;
    assign aborted_o    = aborted_q;

endmodule
